// File: rtl/sample_readout_sequencer.sv
// Read-side sequencer for the acquisition sample buffer: walks RAM addresses
// 0..NSAMPLES-1 and streams the samples out with sop/eop behind a credit-limited FIFO.
module sample_readout_sequencer #(
    parameter int NSAMPLES    = 1170,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sop_o,
    output logic              out_eop_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);
    // state   | meaning
    // IDLE    | waiting for start
    // READ    | issuing RAM reads as FIFO credit allows
    // DRAIN   | all reads issued, emptying FIFO until the eop beat leaves
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(2 * FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NSAMPLES - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [SUM_W-1:0]  DEPTH_S  = SUM_W'(FIFO_DEPTH);

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      beat_q, beat_d;
    logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   done_q, done_d;
    logic [SUM_W-1:0]       inflight, occupancy;
    logic                   push, pop, start_ok, credit_ok, last_beat;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + SUM_W'(pipe_q[i]);
        end
    end

    // A read only goes out if a FIFO slot is already reserved for its data.
    assign occupancy   = SUM_W'(count_q) + inflight;
    assign credit_ok   = occupancy < DEPTH_S;
    assign rd_en_o     = (state_q == S_READ) && credit_ok && !abort_i;
    assign rd_addr_o   = addr_q;
    assign push        = pipe_q[RAM_LATENCY-1];
    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign last_beat   = (beat_q == LAST_IDX);
    assign out_data_o  = out_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
    assign out_sop_o   = out_valid_o && (beat_q == '0);
    assign out_eop_o   = out_valid_o && last_beat;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;
    assign start_ok    = start_i && !abort_i && (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        overrun_d = overrun_q;
        done_d    = pop && last_beat;
        pipe_d    = pipe_q << 1;
        pipe_d[0] = rd_en_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        if (pop)  beat_d   = last_beat ? '0 : beat_q + ADDR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_READ;
                    addr_d    = '0;
                    overrun_d = 1'b0;
                end
            end
            S_READ: begin
                if (rd_en_o) begin
                    if (addr_q == LAST_IDX) state_d = S_DRAIN;
                    else                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (pop && last_beat) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_i && !abort_i && (state_q != S_IDLE)) overrun_d = 1'b1;

        // Abort drops everything, including data still coming back from the RAM.
        if (abort_i) begin
            state_d  = S_IDLE;
            pipe_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            beat_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            beat_q    <= '0;
            pipe_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            pipe_q    <= pipe_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push && !abort_i) fifo_mem_q[wr_ptr_q] <= rd_data_i;
    end

endmodule
